// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared types for the systolic-array input buffer.
// Lane data type, skewed-lane bundle and pointer-width helper.
package ibuf_pkg;

  localparam int DEF_DATA_W = 8;

  typedef logic [DEF_DATA_W-1:0] lane_t;

  typedef struct packed {
    logic  valid;
    lane_t data;
  } skew_lane_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ibuf_skew_fifo_skew_line.sv
// skew_line: step-enabled delay line of LEN data+valid stages.
// Ports: clk, nRST, step, flush, in_valid/in_data, out_valid/out_data, any_valid.
module skew_line #(
  parameter int LEN    = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              step,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              any_valid
);

  logic [LEN-1:0]    vld;
  logic [DATA_W-1:0] dat [LEN];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      vld <= '0;
      for (int k = 0; k < LEN; k++) dat[k] <= '0;
    end else if (flush) begin
      vld <= '0;
      for (int k = 0; k < LEN; k++) dat[k] <= '0;
    end else if (step) begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int k = 1; k < LEN; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[LEN-1];
  assign out_data  = dat[LEN-1];
  assign any_valid = |vld;

endmodule

// File: rtl/ibuf_skew_fifo.sv
// ibuf_skew_fifo: DEPTH-entry vector FIFO feeding a triangular skew network.
// Ports: clk, nRST, wr_valid/wr_ready/wr_data, step, flush, out_data, out_valid, count, busy.
module ibuf_skew_fifo
  import ibuf_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         nRST,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ARRAY_SIZE*DATA_W-1:0] wr_data,
  input  logic                         step,
  input  logic                         flush,
  output logic [ARRAY_SIZE*DATA_W-1:0] out_data,
  output logic [ARRAY_SIZE-1:0]        out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int VW = ARRAY_SIZE * DATA_W;
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;
  logic [VW-1:0]   head;
  logic [ARRAY_SIZE-1:0] lane_any;

  assign wr_ready = (cnt != FULL);
  assign count    = cnt;
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = step && (cnt != '0) && !flush;
  assign head     = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries behind count are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] lane_in;

    // Bubbles carry zero data so idle rows see clean operands.
    assign lane_in = pop ? head[i*DATA_W +: DATA_W] : '0;

    skew_line #(
      .LEN    (i + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk       (clk),
      .nRST      (nRST),
      .step      (step),
      .flush     (flush),
      .in_valid  (pop),
      .in_data   (lane_in),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*DATA_W +: DATA_W]),
      .any_valid (lane_any[i])
    );
  end

  assign busy = (cnt != '0) || (|lane_any);

endmodule

// File: tb/tb_ibuf_skew_fifo.sv
// tb_ibuf_skew_fifo: directed bench with lane-order scoreboard.
// Drives ibuf_skew_fifo with ARRAY_SIZE=4, DATA_W=8, DEPTH=8.
module tb_ibuf_skew_fifo;
  import ibuf_pkg::*;

  localparam int AS = 4;
  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 0;
  logic          nRST = 0;
  logic          wr_valid = 0;
  logic          wr_ready;
  logic [31:0]   wr_data = '0;
  logic          step = 0;
  logic          flush = 0;
  logic [31:0]   out_data;
  logic [3:0]    out_valid;
  logic [3:0]    count;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  int npop = 0;
  int seen [AS];
  bit fresh = 0;
  logic [31:0] exp_q [$];

  ibuf_skew_fifo #(
    .ARRAY_SIZE (AS),
    .DATA_W     (DW),
    .DEPTH      (DP)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .step      (step),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec(input int v);
    logic [31:0] r;
    lane_t l;
    for (int i = 0; i < AS; i++) begin
      l = lane_t'(v * 4 + i);
      r[i*DW +: DW] = l;
    end
    return r;
  endfunction

  task automatic model_clear();
    mcount = 0;
    npop = 0;
    exp_q.delete();
    for (int i = 0; i < AS; i++) seen[i] = 0;
  endtask

  // One clock: drive, update model at the edge, check at edge+1.
  task automatic cyc(input logic wv, input logic [31:0] wd,
                     input logic st, input logic fl);
    bit acc;
    bit pp;
    wr_valid = wv;
    wr_data  = wd;
    step     = st;
    flush    = fl;
    @(posedge clk);
    acc = wv && (mcount != DP) && !fl;
    pp  = st && (mcount != 0) && !fl;
    fresh = st && !fl;
    if (fl) begin
      model_clear();
    end else begin
      if (acc) exp_q.push_back(wd);
      mcount = mcount + int'(acc) - int'(pp);
    end
    #1;
    chk("count", 32'(count), 32'(mcount));
    chk("wr_ready", 32'(wr_ready), 32'(mcount != DP));
    wr_valid = 0;
    step     = 0;
    flush    = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 40) begin
      cyc(0, '0, 1, 0);
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: each lane consumes the pushed vectors in order,
  // only on edges where the network actually advanced.
  always @(negedge clk) begin
    int idx;
    if (nRST && fresh) begin
      for (int i = 0; i < AS; i++) begin
        if (out_valid[i]) begin
          idx = seen[i] - npop;
          checks++;
          assert (idx >= 0 && idx < exp_q.size()) else begin
            errors++;
            $error("FAIL lane%0d_extra: observed %0h expected none",
                   i, out_data[i*DW +: DW]);
          end
          if (idx >= 0 && idx < exp_q.size())
            chk($sformatf("lane%0d_data", i),
                32'(out_data[i*DW +: DW]),
                32'(exp_q[idx][i*DW +: DW]));
          seen[i]++;
        end
      end
      if (out_valid[AS-1] && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        npop++;
      end
    end
  end

  initial begin
    for (int i = 0; i < AS; i++) seen[i] = 0;
    #3;
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    nRST = 1;

    // Skew: lanes {4,3,2,1}
    cyc(1, 32'h04030201, 0, 0);
    cyc(0, '0, 1, 0);
    chk("skew_v0", 32'(out_valid), 32'b0001);
    chk("skew_d0", 32'(out_data[7:0]), 32'd1);
    cyc(0, '0, 1, 0);
    chk("skew_v1", 32'(out_valid), 32'b0010);
    chk("skew_d1", 32'(out_data[15:8]), 32'd2);
    cyc(0, '0, 1, 0);
    chk("skew_v2", 32'(out_valid), 32'b0100);
    chk("skew_d2", 32'(out_data[23:16]), 32'd3);
    cyc(0, '0, 1, 0);
    chk("skew_v3", 32'(out_valid), 32'b1000);
    chk("skew_d3", 32'(out_data[31:24]), 32'd4);
    chk("skew_busy3", 32'(busy), 32'd1);
    cyc(0, '0, 1, 0);
    chk("skew_v4", 32'(out_valid), 32'b0000);
    chk("skew_busy4", 32'(busy), 32'd0);

    // Full and backpressure
    for (int v = 0; v < DP; v++) cyc(1, vec(v + 30), 0, 0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(wr_ready), 32'd0);
    cyc(1, 32'hdeadbeef, 0, 0);
    chk("full_9th", 32'(count), 32'd8);
    cyc(0, '0, 1, 0);
    chk("full_pop_count", 32'(count), 32'd7);
    chk("full_pop_ready", 32'(wr_ready), 32'd1);
    drain();

    // Simultaneous push/pop across wrap
    for (int v = 0; v < 3; v++) cyc(1, vec(v), 0, 0);
    for (int v = 3; v < 20; v++) begin
      cyc(1, vec(v), 1, 0);
      chk("simul_count", 32'(count), 32'd3);
    end
    drain();

    // Step gating: lanes {8,7,6,5}
    cyc(1, 32'h08070605, 0, 0);
    cyc(0, '0, 1, 0);
    chk("gate_v0", 32'(out_valid), 32'b0001);
    chk("gate_d0", 32'(out_data[7:0]), 32'd5);
    for (int k = 0; k < 5; k++) begin
      cyc(0, '0, 0, 0);
      chk("gate_hold_v", 32'(out_valid), 32'b0001);
      chk("gate_hold_d", 32'(out_data[7:0]), 32'd5);
    end
    cyc(0, '0, 1, 0);
    chk("gate_v1", 32'(out_valid), 32'b0010);
    chk("gate_d1", 32'(out_data[15:8]), 32'd6);
    cyc(0, '0, 1, 0);
    chk("gate_v2", 32'(out_valid), 32'b0100);
    chk("gate_d2", 32'(out_data[23:16]), 32'd7);
    cyc(0, '0, 1, 0);
    chk("gate_v3", 32'(out_valid), 32'b1000);
    chk("gate_d3", 32'(out_data[31:24]), 32'd8);
    cyc(0, '0, 1, 0);
    chk("gate_v4", 32'(out_valid), 32'b0000);

    // Flush with 4 queued and lanes valid
    for (int v = 0; v < 6; v++) cyc(1, vec(v + 40), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    chk("flush_pre_count", 32'(count), 32'd4);
    chk("flush_pre_valid", 32'(out_valid), 32'b0011);
    cyc(0, '0, 0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ready", 32'(wr_ready), 32'd1);
    cyc(1, vec(50), 0, 0);
    cyc(1, vec(51), 0, 0);
    cyc(1, vec(52), 0, 1);
    chk("flush_wv_count", 32'(count), 32'd0);
    chk("flush_wv_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-stream
    for (int v = 0; v < 3; v++) cyc(1, vec(v + 60), 0, 0);
    cyc(1, vec(63), 1, 0);
    cyc(1, vec(64), 1, 0);
    nRST = 0;
    fresh = 0;
    #1;
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready), 32'd1);
    model_clear();
    @(negedge clk);
    nRST = 1;

    // Recovery after reset
    for (int v = 0; v < 4; v++) cyc(1, vec(v + 70), 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
